// File: rtl/tank_hit_manager.sv
// Target-side hit handling for one tank: detects enemy rocket strikes, sequences
// explosion -> respawn -> invulnerability, and tracks the remaining lives.
module tank_hit_manager #(
   parameter int INIT_LIVES        = 3,
   parameter int EXPLODE_FRAMES    = 24,
   parameter int FRAMES_PER_SPRITE = 3,
   parameter int RESPAWN_FRAMES    = 30,
   parameter int INVULN_FRAMES     = 60,
   parameter int BLINK_FRAMES      = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       rocket_enable,
   input  logic       rocket_tank_collision,
   input  logic       new_game,
   output logic       tank_death,
   output logic       rocket_absorb,
   output logic       respawn,
   output logic       tank_visible,
   output logic       tank_move_en,
   output logic       explosion_enable,
   output logic [2:0] explosion_frame,
   output logic [2:0] lives,
   output logic       game_over
);

   localparam int CNT_MAX_A = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES;
   localparam int CNT_MAX   = (CNT_MAX_A > INVULN_FRAMES) ? CNT_MAX_A : INVULN_FRAMES;
   localparam int CW        = (CNT_MAX < 8) ? 3 : $clog2(CNT_MAX + 1);
   localparam int BLINK_BIT = $clog2(BLINK_FRAMES);

   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] EXP_LAST   = CW'(EXPLODE_FRAMES - 1);
   localparam logic [CW-1:0] RSP_LAST   = CW'(RESPAWN_FRAMES - 1);
   localparam logic [CW-1:0] INV_LAST   = CW'(INVULN_FRAMES - 1);
   localparam logic [CW-1:0] SPRITE_DIV = CW'(FRAMES_PER_SPRITE);
   localparam logic [CW-1:0] SPRITE_MAX = CW'(7);
   localparam logic [2:0]    LIVES_INIT = 3'(INIT_LIVES);

   typedef enum logic [2:0] {
      ST_ALIVE     = 3'd0,
      ST_EXPLODE   = 3'd1,
      ST_RESPAWN   = 3'd2,
      ST_INVULN    = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   state_t        r_state, w_state_n;
   logic [CW-1:0] r_cnt, w_cnt_n, w_cnt_inc, w_sprite;
   logic [2:0]    r_lives, w_lives_n;
   logic          r_armed, w_armed_n;
   logic          w_strike;
   logic          w_death_n, w_absorb_n, w_respawn_n;
   logic          w_visible_n, w_move_n, w_expl_en_n, w_game_over_n;
   logic [2:0]    w_expl_frame_n;
   logic          r_death, r_absorb, r_respawn, r_visible, r_move, r_expl_en, r_game_over;
   logic [2:0]    r_expl_frame;

   assign w_strike  = rocket_tank_collision & rocket_enable & r_armed;
   assign w_cnt_inc = r_cnt + CNT_ONE;
   assign w_sprite  = w_cnt_n / SPRITE_DIV;

   // Next-state, frame counter, lives, re-arm and pulse decisions
   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_lives_n   = r_lives;
      w_armed_n   = r_armed;
      w_death_n   = 1'b0;
      w_absorb_n  = 1'b0;
      w_respawn_n = 1'b0;
      if (!rocket_enable) begin
         w_armed_n = 1'b1;
      end else begin
         w_armed_n = r_armed;
      end
      if (new_game) begin
         w_state_n = ST_ALIVE;
         w_cnt_n   = CNT_ZERO;
         w_lives_n = LIVES_INIT;
         w_armed_n = 1'b1;
      end else begin
         case (r_state)
            ST_ALIVE: begin
               // a strike wins over a coincident frame pulse; ALIVE has no frame count
               if (w_strike) begin
                  w_state_n  = ST_EXPLODE;
                  w_cnt_n    = CNT_ZERO;
                  w_lives_n  = (r_lives == 3'd0) ? 3'd0 : (r_lives - 3'd1);
                  w_armed_n  = 1'b0;
                  w_death_n  = 1'b1;
                  w_absorb_n = 1'b1;
               end else begin
                  w_state_n = ST_ALIVE;
               end
            end
            ST_EXPLODE: begin
               if (startOfFrame) begin
                  if (r_cnt == EXP_LAST) begin
                     w_cnt_n   = CNT_ZERO;
                     w_state_n = (r_lives == 3'd0) ? ST_GAME_OVER : ST_RESPAWN;
                  end else begin
                     w_cnt_n = w_cnt_inc;
                  end
               end else begin
                  w_cnt_n = r_cnt;
               end
            end
            ST_RESPAWN: begin
               if (startOfFrame) begin
                  if (r_cnt == RSP_LAST) begin
                     w_cnt_n     = CNT_ZERO;
                     w_state_n   = ST_INVULN;
                     w_respawn_n = 1'b1;
                  end else begin
                     w_cnt_n = w_cnt_inc;
                  end
               end else begin
                  w_cnt_n = r_cnt;
               end
            end
            ST_INVULN: begin
               if (w_strike) begin
                  w_armed_n  = 1'b0;
                  w_absorb_n = 1'b1;
               end else begin
                  w_absorb_n = 1'b0;
               end
               if (startOfFrame) begin
                  if (r_cnt == INV_LAST) begin
                     w_cnt_n   = CNT_ZERO;
                     w_state_n = ST_ALIVE;
                  end else begin
                     w_cnt_n = w_cnt_inc;
                  end
               end else begin
                  w_cnt_n = r_cnt;
               end
            end
            ST_GAME_OVER: begin
               w_state_n = ST_GAME_OVER;
            end
            default: begin
               w_state_n = ST_ALIVE;
               w_cnt_n   = CNT_ZERO;
            end
         endcase
      end
   end

   // Level outputs derived from the next state so they register in step with it
   always_comb begin
      w_visible_n    = 1'b0;
      w_move_n       = 1'b0;
      w_expl_en_n    = 1'b0;
      w_expl_frame_n = 3'd0;
      w_game_over_n  = 1'b0;
      case (w_state_n)
         ST_ALIVE: begin
            w_visible_n = 1'b1;
            w_move_n    = 1'b1;
         end
         ST_EXPLODE: begin
            w_expl_en_n = 1'b1;
            if (w_sprite > SPRITE_MAX) begin
               w_expl_frame_n = 3'd7;
            end else begin
               w_expl_frame_n = w_sprite[2:0];
            end
         end
         ST_RESPAWN: begin
            w_visible_n = 1'b0;
         end
         ST_INVULN: begin
            w_move_n    = 1'b1;
            w_visible_n = ~w_cnt_n[BLINK_BIT];
         end
         ST_GAME_OVER: begin
            w_game_over_n = 1'b1;
         end
         default: begin
            w_visible_n = 1'b0;
         end
      endcase
   end

   // Core state registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_ALIVE;
         r_cnt   <= CNT_ZERO;
         r_lives <= LIVES_INIT;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_lives <= w_lives_n;
         r_armed <= w_armed_n;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_death      <= 1'b0;
         r_absorb     <= 1'b0;
         r_respawn    <= 1'b0;
         r_visible    <= 1'b1;
         r_move       <= 1'b1;
         r_expl_en    <= 1'b0;
         r_expl_frame <= 3'd0;
         r_game_over  <= 1'b0;
      end else begin
         r_death      <= w_death_n;
         r_absorb     <= w_absorb_n;
         r_respawn    <= w_respawn_n;
         r_visible    <= w_visible_n;
         r_move       <= w_move_n;
         r_expl_en    <= w_expl_en_n;
         r_expl_frame <= w_expl_frame_n;
         r_game_over  <= w_game_over_n;
      end
   end

   assign tank_death       = r_death;
   assign rocket_absorb    = r_absorb;
   assign respawn          = r_respawn;
   assign tank_visible     = r_visible;
   assign tank_move_en     = r_move;
   assign explosion_enable = r_expl_en;
   assign explosion_frame  = r_expl_frame;
   assign lives            = r_lives;
   assign game_over        = r_game_over;

endmodule

// File: tb/tb_tank_hit_manager.sv
// Self-checking bench for tank_hit_manager: a phase/frames-remaining model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tank_hit_manager;

   localparam int INIT_LIVES     = 3;
   localparam int EXPLODE_FRAMES = 24;
   localparam int FPS            = 3;
   localparam int RESPAWN_FRAMES = 30;
   localparam int INVULN_FRAMES  = 60;
   localparam int BLINK_FRAMES   = 4;

   localparam int P_ALIVE = 0, P_EXPLODE = 1, P_RESPAWN = 2, P_INVULN = 3, P_GAME_OVER = 4;

   logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, ren = 1'b0, col = 1'b0, ng = 1'b0;
   logic tank_death, rocket_absorb, respawn, tank_visible, tank_move_en;
   logic explosion_enable, game_over;
   logic [2:0] explosion_frame, lives;

   int errors = 0, checks = 0;
   int n_death = 0, n_absorb = 0, n_respawn = 0;

   always #5 clk = ~clk;

   tank_hit_manager dut (
      .clk                   (clk),
      .resetN                (resetN),
      .startOfFrame          (sof),
      .rocket_enable         (ren),
      .rocket_tank_collision (col),
      .new_game              (ng),
      .tank_death            (tank_death),
      .rocket_absorb         (rocket_absorb),
      .respawn               (respawn),
      .tank_visible          (tank_visible),
      .tank_move_en          (tank_move_en),
      .explosion_enable      (explosion_enable),
      .explosion_frame       (explosion_frame),
      .lives                 (lives),
      .game_over             (game_over)
   );

   typedef struct packed {
      int phase;
      int left;
      int nlives;
      bit armed;
      bit death;
      bit absorb;
      bit resp;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.phase = P_ALIVE; r.left = 0; r.nlives = INIT_LIVES; r.armed = 1'b1;
      r.death = 1'b0; r.absorb = 1'b0; r.resp = 1'b0;
      return r;
   endfunction

   function automatic model_t model_step(model_t s, bit sof_i, bit en_i, bit col_i, bit ng_i);
      model_t n;
      bit strike;
      n = s;
      n.death = 1'b0; n.absorb = 1'b0; n.resp = 1'b0;
      if (ng_i) begin
         n.phase = P_ALIVE; n.left = 0; n.nlives = INIT_LIVES; n.armed = 1'b1;
         return n;
      end
      strike = col_i && en_i && s.armed;
      if (!en_i) n.armed = 1'b1;
      if (s.phase == P_ALIVE) begin
         if (strike) begin
            n.nlives = (s.nlives > 0) ? s.nlives - 1 : 0;
            n.death = 1'b1; n.absorb = 1'b1; n.armed = 1'b0;
            n.phase = P_EXPLODE; n.left = EXPLODE_FRAMES;
         end
      end else if (s.phase != P_GAME_OVER) begin
         if (s.phase == P_INVULN && strike) begin
            n.absorb = 1'b1; n.armed = 1'b0;
         end
         if (sof_i) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
               if (s.phase == P_EXPLODE) begin
                  if (s.nlives == 0) begin n.phase = P_GAME_OVER; n.left = 0; end
                  else begin n.phase = P_RESPAWN; n.left = RESPAWN_FRAMES; end
               end else if (s.phase == P_RESPAWN) begin
                  n.phase = P_INVULN; n.left = INVULN_FRAMES; n.resp = 1'b1;
               end else begin
                  n.phase = P_ALIVE; n.left = 0;
               end
            end
         end
      end
      return n;
   endfunction

   function automatic int exp_visible(model_t s);
      if (s.phase == P_ALIVE) return 1;
      if (s.phase == P_INVULN) return (((INVULN_FRAMES - s.left) / BLINK_FRAMES) % 2 == 0) ? 1 : 0;
      return 0;
   endfunction

   function automatic int exp_frame(model_t s);
      int e;
      if (s.phase != P_EXPLODE) return 0;
      e = (EXPLODE_FRAMES - s.left) / FPS;
      return (e > 7) ? 7 : e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model update (async reset like the DUT)
   always @(posedge clk or negedge resetN) begin
      if (!resetN) m <= model_reset();
      else         m <= model_step(m, sof, ren, col, ng);
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_death",     int'(tank_death),       int'(m.death));
      chk("m_absorb",    int'(rocket_absorb),    int'(m.absorb));
      chk("m_respawn",   int'(respawn),          int'(m.resp));
      chk("m_visible",   int'(tank_visible),     exp_visible(m));
      chk("m_move_en",   int'(tank_move_en),     (m.phase == P_ALIVE || m.phase == P_INVULN) ? 1 : 0);
      chk("m_expl_en",   int'(explosion_enable), (m.phase == P_EXPLODE) ? 1 : 0);
      chk("m_expl_frame",int'(explosion_frame),  exp_frame(m));
      chk("m_lives",     int'(lives),            m.nlives);
      chk("m_game_over", int'(game_over),        (m.phase == P_GAME_OVER) ? 1 : 0);
   end

   // Pulse tallies seen on the DUT
   always @(negedge clk) begin
      if (tank_death)    n_death   <= n_death + 1;
      if (rocket_absorb) n_absorb  <= n_absorb + 1;
      if (respawn)       n_respawn <= n_respawn + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk); sof = 1'b1;
      @(negedge clk); sof = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   task automatic hit();
      @(negedge clk); col = 1'b1; ren = 1'b1;
      @(negedge clk); col = 1'b0; ren = 1'b0;
   endtask

   initial begin
      cyc(2);
      resetN = 1'b1;
      cyc(3);
      chk("rst_lives", int'(lives), 3);
      chk("rst_visible", int'(tank_visible), 1);
      chk("rst_move_en", int'(tank_move_en), 1);
      chk("rst_expl_en", int'(explosion_enable), 0);
      chk("rst_game_over", int'(game_over), 0);

      // held overlap in ALIVE: one hit only, one cycle after the first overlap
      @(negedge clk); col = 1'b1; ren = 1'b1;
      @(negedge clk);
      chk("hit1_death_pulse", int'(tank_death), 1);
      chk("hit1_absorb_pulse", int'(rocket_absorb), 1);
      cyc(499);
      chk("hit1_death_count", n_death, 1);
      chk("hit1_absorb_count", n_absorb, 1);
      chk("hit1_lives", int'(lives), 2);
      col = 1'b0; ren = 1'b0;

      // explosion sprite stepping
      for (int f = 0; f < EXPLODE_FRAMES; f++) begin
         chk("expl_frame_step", int'(explosion_frame), f / 3);
         frame();
      end
      chk("respawn_expl_off", int'(explosion_enable), 0);
      chk("respawn_hidden", int'(tank_visible), 0);
      frames(29);
      chk("respawn_not_yet", n_respawn, 0);
      frame();
      chk("respawn_pulse_count", n_respawn, 1);
      chk("invuln_move_en", int'(tank_move_en), 1);
      chk("invuln_vis_start", int'(tank_visible), 1);
      frames(4);
      chk("invuln_vis_blink_off", int'(tank_visible), 0);
      frames(4);
      chk("invuln_vis_blink_on", int'(tank_visible), 1);

      // absorb during INVULN; second overlap before rocket drops ignored
      @(negedge clk); col = 1'b1; ren = 1'b1;
      cyc(2); col = 1'b0;
      cyc(2); col = 1'b1;
      cyc(2); col = 1'b0; ren = 1'b0;
      cyc(2);
      chk("invuln_absorb_count", n_absorb, 2);
      chk("invuln_no_death", n_death, 1);
      chk("invuln_lives", int'(lives), 2);
      frames(52);
      chk("alive_again_visible", int'(tank_visible), 1);
      chk("alive_again_move", int'(tank_move_en), 1);

      // run down to GAME_OVER
      hit();
      frames(114);
      chk("hit2_lives", int'(lives), 1);
      chk("hit2_alive", int'(tank_move_en), 1);
      hit();
      frames(23);
      chk("last_expl_not_over", int'(game_over), 0);
      chk("last_expl_enable", int'(explosion_enable), 1);
      frame();
      chk("game_over_level", int'(game_over), 1);
      chk("game_over_lives", int'(lives), 0);
      chk("game_over_move", int'(tank_move_en), 0);
      hit();
      cyc(2);
      chk("game_over_ignores_hit", n_death, 3);
      @(negedge clk); ng = 1'b1;
      @(negedge clk); ng = 1'b0;
      chk("new_game_lives", int'(lives), 3);
      chk("new_game_not_over", int'(game_over), 0);
      chk("new_game_visible", int'(tank_visible), 1);

      // new_game beats a coincident collision
      hit();
      frames(114);
      chk("pre_ng_lives", int'(lives), 2);
      @(negedge clk); ng = 1'b1; col = 1'b1; ren = 1'b1;
      @(negedge clk);
      chk("ng_col_no_death", int'(tank_death), 0);
      chk("ng_col_no_absorb", int'(rocket_absorb), 0);
      chk("ng_col_lives", int'(lives), 3);
      chk("ng_col_alive", int'(tank_visible), 1);
      ng = 1'b0; col = 1'b0; ren = 1'b0;
      cyc(2);
      chk("ng_col_death_count", n_death, 4);

      // collision together with startOfFrame is a hit starting at sprite 0
      @(negedge clk); col = 1'b1; ren = 1'b1; sof = 1'b1;
      @(negedge clk);
      chk("sof_hit_death", int'(tank_death), 1);
      chk("sof_hit_frame", int'(explosion_frame), 0);
      col = 1'b0; ren = 1'b0; sof = 1'b0;
      frames(7);
      chk("sof_hit_frame7", int'(explosion_frame), 2);
      chk("sof_hit_lives", int'(lives), 2);

      // asynchronous reset mid-explosion
      @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      chk("async_expl_en", int'(explosion_enable), 0);
      chk("async_frame", int'(explosion_frame), 0);
      chk("async_lives", int'(lives), 3);
      chk("async_visible", int'(tank_visible), 1);
      chk("async_move", int'(tank_move_en), 1);
      @(negedge clk); resetN = 1'b1;
      cyc(3);
      chk("post_reset_lives", int'(lives), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
